instr_prefetch: RTL and testbench
=================================

INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, buffer entries; power of two, 2..16.
REQ-002 SHALL have parameter RESET_ADDR, default 32'h0, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port cpu_read  input  1  CPU fetch request, held until cpu_readdatavalid.
REQ-006 SHALL have port cpu_address  input  32  CPU fetch byte address.
REQ-007 SHALL have port cpu_byteenable  input  4  accepted and ignored.
REQ-008 SHALL have port cpu_readdata  output  32  instruction word, byte order unchanged from memory.
REQ-009 SHALL have port cpu_waitrequest  output  1  request not yet served.
REQ-010 SHALL have port cpu_readdatavalid  output  1  cpu_readdata valid this cycle.
REQ-011 SHALL have port mem_read  output  1  memory read request.
REQ-012 SHALL have port mem_address  output  32  memory byte address.
REQ-013 SHALL have port mem_byteenable  output  4  constant 4'b1111.
REQ-014 SHALL have port mem_readdata  input  32  memory response data.
REQ-015 SHALL have port mem_waitrequest  input  1  memory stalls current request.
REQ-016 SHALL have port mem_readdatavalid  input  1  memory response valid, in request order.

Function
REQ-017 SHALL hold a FIFO of up to DEPTH words for consecutive addresses starting at head_addr; state: count, outstanding (accepted, unreturned reads), fetch_addr (next issue), discard counter, pending flag.
REQ-018 Hit: cpu_read=1, count>0, cpu_address==head_addr -> same cycle cpu_readdatavalid=1, cpu_readdata=FIFO head, cpu_waitrequest=0; on the edge pop, head_addr+=4.
REQ-019 cpu_waitrequest SHALL equal cpu_read && !cpu_readdatavalid; cpu_readdatavalid=0 whenever cpu_read=0.
REQ-020 Wait: cpu_read=1, count==0, cpu_address==head_addr -> no response, no flush; served when the word arrives (earliest the cycle after mem_readdatavalid).
REQ-021 Miss: cpu_read=1, cpu_address!=head_addr -> on the edge FIFO emptied, head_addr=fetch_addr=cpu_address, discard+=outstanding (minus 1 if a response arrives that same cycle); no response that cycle.
REQ-022 mem_read SHALL be 1 when discard==0 and count+outstanding<DEPTH, or while pending=1; mem_address=fetch_addr.
REQ-023 mem_read=1 with mem_waitrequest=1 SHALL set pending; mem_read and mem_address held unchanged until mem_waitrequest=0, even across a miss.
REQ-024 A miss while pending=1 SHALL mark that request for discard: discard+1 on acceptance; fetch_addr updates only after acceptance.
REQ-025 Acceptance (mem_read && !mem_waitrequest): outstanding+1, fetch_addr+=4 unless discard-marked, pending cleared.
REQ-026 mem_readdatavalid: outstanding-1; if discard>0 drop word and discard-1; else push at tail.
REQ-027 FIFO push and CPU pop in one cycle SHALL leave count unchanged; count never exceeds DEPTH, never underflows.
REQ-028 Address arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4=32'h0; low two bits carried unchanged, never realigned.
REQ-029 States: RUN (discard==0, issuing allowed), DRAIN (discard>0, no new issues, responses dropped); DRAIN->RUN on the edge discard reaches 0; a miss in DRAIN redirects addresses and stays in DRAIN.

Reset
REQ-030 rst=0 SHALL asynchronously set count=0, outstanding=0, discard=0, pending=0, head_addr=fetch_addr=RESET_ADDR, cpu_readdatavalid=0, cpu_waitrequest=cpu_read, mem_read=0.
REQ-031 First mem_read SHALL assert the first cycle after rst deasserts.
REQ-032 Reset mid-operation SHALL abandon in-flight reads; memory must be reset together.

Verification
REQ-033 Sequential: zero-wait memory, latency 1, CPU fetches 0x0,0x4,0x8 back-to-back -> three hits, data in order, mem_address 0x0..0xC, count<=4.
REQ-034 Full: CPU idle 10 cycles after reset -> exactly 4 reads issued (0x0..0xC), mem_read=0 after, count=4.
REQ-035 Branch: two reads outstanding, CPU requests 0x100 -> both responses dropped, next issue 0x100, first delivered word from 0x100.
REQ-036 Waitrequest: mem_waitrequest=1 for 3 cycles on 0x8, miss to 0x40 in cycle 2 -> mem_address stays 0x8 until accepted, its data dropped, next issue 0x40.
REQ-037 Wrap: RESET_ADDR=32'hFFFF_FFF8 -> issues 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4.
REQ-038 Reset: rst=0 with 3 outstanding -> next cycle mem_read=0, count=0; after release fetch restarts at RESET_ADDR.

Source files
------------

// File: rtl/instr_prefetch.sv
// instr_prefetch: sequential instruction prefetch buffer between a CPU fetch
// port and a pipelined memory read port (Avalon-MM style).
//
// The buffer holds up to DEPTH words for consecutive addresses starting at
// head_addr. A request matching head_addr is served from the buffer head in
// the same cycle. A request to any other address flushes the buffer, redirects
// fetching and drains the reads still in flight.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   cpu_read            CPU fetch request, held until cpu_readdatavalid
//   cpu_address         CPU fetch byte address
//   cpu_byteenable      accepted and ignored
//   cpu_readdata        instruction word (memory byte order)
//   cpu_waitrequest     request not served this cycle
//   cpu_readdatavalid   cpu_readdata valid this cycle
//   mem_read            memory read request
//   mem_address         memory byte address
//   mem_byteenable      always 4'b1111
//   mem_readdata        memory response data
//   mem_waitrequest     memory stalls the current request
//   mem_readdatavalid   memory response valid, in request order
module instr_prefetch #(
   parameter int unsigned DEPTH      = 4,
   parameter logic [31:0] RESET_ADDR = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_read,
   input  logic [31:0] cpu_address,
   input  logic [3:0]  cpu_byteenable,
   output logic [31:0] cpu_readdata,
   output logic        cpu_waitrequest,
   output logic        cpu_readdatavalid,
   output logic        mem_read,
   output logic [31:0] mem_address,
   output logic [3:0]  mem_byteenable,
   input  logic [31:0] mem_readdata,
   input  logic        mem_waitrequest,
   input  logic        mem_readdatavalid
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = CW + 1;

   // RUN: issuing allowed. DRAIN: stale reads in flight, responses dropped.
   typedef enum logic {RUN, DRAIN} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           count_q, count_d;
   logic [CW-1:0]           outst_q, outst_d;
   logic [CW-1:0]           discard_q, discard_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [31:0]             head_addr_q, head_addr_d;
   logic [31:0]             fetch_addr_q, fetch_addr_d;
   logic [31:0]             redir_addr_q, redir_addr_d;
   logic                    pending_q, pending_d;
   logic                    mark_q, mark_d;
   logic [DEPTH-1:0][31:0]  fifo_q, fifo_d;

   logic hit, miss, room, accept, stall, stale, push, drop;
   logic unused_be;

   assign unused_be = ^cpu_byteenable;

   assign hit    = cpu_read && (count_q != '0) && (cpu_address == head_addr_q);
   assign miss   = cpu_read && (cpu_address != head_addr_q);
   assign room   = ({1'b0, count_q} + {1'b0, outst_q}) < SW'(DEPTH);
   // Gated by rst so nothing is requested while held in reset; the first
   // request appears as soon as reset is released.
   assign mem_read = rst && (pending_q || ((state_q == RUN) && room));
   assign accept = mem_read && !mem_waitrequest;
   assign stall  = mem_read && mem_waitrequest;
   // The word accepted this cycle is for a superseded address when a miss
   // arrived while it was stalled (mark_q) or arrives in the accepting cycle.
   assign stale  = accept && (mark_q || miss);
   assign drop   = mem_readdatavalid && (state_q == DRAIN);
   assign push   = mem_readdatavalid && (state_q == RUN);

   assign cpu_readdatavalid = hit;
   assign cpu_waitrequest   = cpu_read && !hit;
   assign cpu_readdata      = fifo_q[rd_ptr_q];
   assign mem_address       = fetch_addr_q;
   assign mem_byteenable    = 4'b1111;

   always_comb begin
      fifo_d       = fifo_q;
      count_d      = count_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      head_addr_d  = head_addr_q;
      fetch_addr_d = fetch_addr_q;
      discard_d    = discard_q;
      outst_d      = outst_q + CW'(accept) - CW'(mem_readdatavalid);
      pending_d    = stall;
      // A redirect during a stall is remembered; the stalled request keeps
      // its address on the bus until memory takes it.
      mark_d       = stall && (mark_q || miss);
      redir_addr_d = (stall && miss) ? cpu_address : redir_addr_q;

      if (miss) begin
         count_d     = '0;
         rd_ptr_d    = '0;
         wr_ptr_d    = '0;
         head_addr_d = cpu_address;
         // Everything still in flight after this edge is for old addresses.
         discard_d   = outst_q - CW'(mem_readdatavalid) + CW'(stale);
      end else begin
         if (push) begin
            fifo_d[wr_ptr_q] = mem_readdata;
            wr_ptr_d         = wr_ptr_q + PW'(1);
         end
         if (hit) begin
            rd_ptr_d    = rd_ptr_q + PW'(1);
            head_addr_d = head_addr_q + 32'd4;
         end
         count_d   = count_q + CW'(push) - CW'(hit);
         discard_d = discard_q - CW'(drop) + CW'(stale);
      end

      if (miss && !stall)
         fetch_addr_d = cpu_address;
      else if (accept)
         fetch_addr_d = mark_q ? redir_addr_q : fetch_addr_q + 32'd4;

      state_d = (discard_d != '0) ? DRAIN : RUN;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= RUN;
         count_q      <= '0;
         outst_q      <= '0;
         discard_q    <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         head_addr_q  <= RESET_ADDR;
         fetch_addr_q <= RESET_ADDR;
         redir_addr_q <= RESET_ADDR;
         pending_q    <= 1'b0;
         mark_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         outst_q      <= outst_d;
         discard_q    <= discard_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         head_addr_q  <= head_addr_d;
         fetch_addr_q <= fetch_addr_d;
         redir_addr_q <= redir_addr_d;
         pending_q    <= pending_d;
         mark_q       <= mark_d;
      end
   end

   // Data storage needs no reset: count_q gates every read of it.
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end
endmodule

// File: tb/tb_instr_prefetch.sv
// Testbench for instr_prefetch. A memory model answers reads in order with
// configurable latency and stalls; the reference rule is that every word
// delivered to the CPU equals the memory word at the requested address.
module tb_instr_prefetch;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_read;
   logic [31:0] cpu_address;
   logic [3:0]  cpu_byteenable;
   logic [31:0] cpu_readdata;
   logic        cpu_waitrequest;
   logic        cpu_readdatavalid;
   logic        mem_read;
   logic [31:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_readdata;
   logic        mem_waitrequest;
   logic        mem_readdatavalid;

   // second instance: wrap-around reset address, idle CPU, memory never answers
   logic        w_cpu_read;
   logic [31:0] w_cpu_address;
   logic [3:0]  w_cpu_byteenable;
   logic [31:0] w_cpu_readdata;
   logic        w_cpu_waitrequest;
   logic        w_cpu_readdatavalid;
   logic        w_mem_read;
   logic [31:0] w_mem_address;
   logic [3:0]  w_mem_byteenable;
   logic [31:0] w_mem_readdata;
   logic        w_mem_waitrequest;
   logic        w_mem_readdatavalid;

   int checks = 0;
   int errors = 0;

   // memory model configuration
   int          wr_pct = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   logic [31:0] stall_addr = 32'h0;
   int          stall_left = 0;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } rsp_t;

   rsp_t        rsp_q[$];
   logic [31:0] acc_q[$];
   logic [31:0] w_acc[$];
   int          cyc = 0;

   always #5 clk = ~clk;

   instr_prefetch #(.DEPTH(DEPTH), .RESET_ADDR(32'h0)) dut (
      .clk(clk), .rst(rst),
      .cpu_read(cpu_read), .cpu_address(cpu_address), .cpu_byteenable(cpu_byteenable),
      .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
      .cpu_readdatavalid(cpu_readdatavalid),
      .mem_read(mem_read), .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
      .mem_readdatavalid(mem_readdatavalid)
   );

   instr_prefetch #(.DEPTH(DEPTH), .RESET_ADDR(32'hFFFF_FFF8)) u_wrap (
      .clk(clk), .rst(rst),
      .cpu_read(w_cpu_read), .cpu_address(w_cpu_address), .cpu_byteenable(w_cpu_byteenable),
      .cpu_readdata(w_cpu_readdata), .cpu_waitrequest(w_cpu_waitrequest),
      .cpu_readdatavalid(w_cpu_readdatavalid),
      .mem_read(w_mem_read), .mem_address(w_mem_address), .mem_byteenable(w_mem_byteenable),
      .mem_readdata(w_mem_readdata), .mem_waitrequest(w_mem_waitrequest),
      .mem_readdatavalid(w_mem_readdatavalid)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[7:0], a[15:8], ~a[23:16], a[31:24]} ^ 32'h1357_9BDF;
   endfunction

   // Memory model: acts 1 time unit after each falling edge, so its decisions
   // take effect at the following rising edge.
   initial begin
      logic        prev_stall;
      logic [31:0] prev_addr;
      logic        wr;
      prev_stall        = 1'b0;
      prev_addr         = 32'h0;
      mem_waitrequest   = 1'b0;
      mem_readdatavalid = 1'b0;
      mem_readdata      = 32'h0;
      forever begin
         @(negedge clk);
         #1;
         cyc++;
         if (!rst) begin
            rsp_q.delete();
            acc_q.delete();
            mem_waitrequest   = 1'b0;
            mem_readdatavalid = 1'b0;
            prev_stall        = 1'b0;
         end else begin
            if (prev_stall) begin
               checks++;
               if (mem_read !== 1'b1 || mem_address !== prev_addr) begin
                  errors++;
                  $display("FAIL stall_hold: mem_read=%b mem_address=%h, required 1 and %h",
                           mem_read, mem_address, prev_addr);
               end
            end
            mem_readdatavalid = 1'b0;
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
               mem_readdatavalid = 1'b1;
               mem_readdata      = mem_word(rsp_q[0].addr);
               void'(rsp_q.pop_front());
            end
            wr = 1'b0;
            if (mem_read === 1'b1) begin
               if (stall_left > 0 && mem_address == stall_addr) begin
                  wr = 1'b1;
                  stall_left--;
               end else if ($urandom_range(99) < wr_pct) begin
                  wr = 1'b1;
               end
            end
            mem_waitrequest = wr;
            if (mem_read === 1'b1 && !wr) begin
               acc_q.push_back(mem_address);
               rsp_q.push_back('{addr: mem_address, due: cyc + $urandom_range(lat_max, lat_min)});
            end
            prev_stall = (mem_read === 1'b1) && wr;
            prev_addr  = mem_address;
            checks++;
            if (rsp_q.size() > DEPTH) begin
               errors++;
               $display("FAIL inflight: %0d reads in flight, required at most %0d", rsp_q.size(), DEPTH);
            end
         end
      end
   end

   // issue log of the wrap instance (its memory never stalls)
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst) w_acc.delete();
         else if (w_mem_read === 1'b1) w_acc.push_back(w_mem_address);
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Called at a falling edge; returns at a falling edge with cpu_read low.
   task automatic cpu_fetch(input logic [31:0] a, input int budget, output logic [31:0] d,
                            output int lat, output bit ok, output bit wr_ok);
      cpu_read       = 1'b1;
      cpu_address    = a;
      cpu_byteenable = 4'($urandom);
      lat   = 0;
      ok    = 1'b0;
      wr_ok = 1'b1;
      d     = 32'h0;
      while (!ok && lat < budget) begin
         #1;
         if (cpu_waitrequest !== !cpu_readdatavalid) wr_ok = 1'b0;
         if (cpu_readdatavalid === 1'b1) begin
            d  = cpu_readdata;
            ok = 1'b1;
         end
         @(negedge clk);
         if (!ok) lat++;
      end
      cpu_read = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b0;
      cpu_read = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      cpu_read    = 1'b1;
      cpu_address = 32'h40;
      #1;
      checks++;
      if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read: got %b want 0", mem_read); end
      checks++;
      if (cpu_readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_rdv: got %b want 0", cpu_readdatavalid); end
      checks++;
      if (cpu_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_waitreq_hi: got %b want 1", cpu_waitrequest); end
      checks++;
      if (mem_byteenable !== 4'hF) begin errors++; $display("FAIL byteenable: got %h want f", mem_byteenable); end
      cpu_read = 1'b0;
      #1;
      checks++;
      if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL rst_waitreq_lo: got %b want 0", cpu_waitrequest); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (mem_read !== 1'b1 || mem_address !== 32'h0) begin
         errors++;
         $display("FAIL first_issue: got mem_read=%b addr=%h want 1 and 0", mem_read, mem_address);
      end
   endtask

   task automatic test_full();
      logic [31:0] d;
      int lat;
      bit ok, wok;
      wr_pct = 0; lat_min = 1; lat_max = 1;
      do_reset();
      repeat (10) @(negedge clk);
      #2;
      checks++;
      if (acc_q.size() != 4) begin errors++; $display("FAIL full_issues: got %0d want 4", acc_q.size()); end
      for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
         checks++;
         if (acc_q[i] !== 32'(4 * i)) begin errors++; $display("FAIL full_addr%0d: got %h want %h", i, acc_q[i], 4 * i); end
      end
      checks++;
      if (mem_read !== 1'b0) begin errors++; $display("FAIL full_idle: mem_read got %b want 0", mem_read); end
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         cpu_fetch(32'(4 * i), 20, d, lat, ok, wok);
         checks++;
         if (!ok || lat != 0 || d !== mem_word(32'(4 * i))) begin
            errors++;
            $display("FAIL full_hit%0d: ok=%b lat=%0d data=%h want 0 latency data %h", i, ok, lat, d, mem_word(32'(4 * i)));
         end
      end
   endtask

   task automatic test_sequential();
      logic [31:0] d;
      int lat;
      bit ok, wok;
      wr_pct = 0; lat_min = 1; lat_max = 1;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cpu_fetch(32'(4 * i), 20, d, lat, ok, wok);
         checks++;
         if (!ok || d !== mem_word(32'(4 * i)) || (i > 0 && lat != 0)) begin
            errors++;
            $display("FAIL seq%0d: ok=%b lat=%0d data=%h want data %h", i, ok, lat, d, mem_word(32'(4 * i)));
         end
      end
      #2;
      checks++;
      if (acc_q.size() < 4 || acc_q[0] !== 32'h0 || acc_q[1] !== 32'h4 || acc_q[2] !== 32'h8 || acc_q[3] !== 32'hC) begin
         errors++;
         $display("FAIL seq_issue: %0d issues logged, want 0,4,8,c first", acc_q.size());
      end
      @(negedge clk);
   endtask

   task automatic test_branch();
      logic [31:0] d;
      int lat, n;
      bit ok, wok;
      wr_pct = 0; lat_min = 3; lat_max = 3;
      do_reset();
      repeat (2) @(negedge clk);
      n = acc_q.size();
      checks++;
      if (n != 2) begin errors++; $display("FAIL br_outstanding: got %0d want 2", n); end
      cpu_fetch(32'h100, 40, d, lat, ok, wok);
      checks++;
      if (!ok || d !== mem_word(32'h100)) begin
         errors++;
         $display("FAIL br_data: ok=%b data=%h want %h", ok, d, mem_word(32'h100));
      end
      checks++;
      if (acc_q.size() < n + 2 || acc_q[n] !== 32'h8 || acc_q[n + 1] !== 32'h100) begin
         errors++;
         $display("FAIL br_issue: after miss want 8 then 100, log size %0d", acc_q.size());
      end
   endtask

   task automatic test_waitreq();
      logic [31:0] d;
      int lat;
      bit ok, wok;
      wr_pct = 0; lat_min = 1; lat_max = 1;
      stall_addr = 32'h8; stall_left = 3;
      do_reset();
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (mem_read !== 1'b1 || mem_address !== 32'h8) begin
         errors++;
         $display("FAIL wr_stalled: mem_read=%b addr=%h want 1 and 8", mem_read, mem_address);
      end
      @(negedge clk);
      cpu_fetch(32'h40, 40, d, lat, ok, wok);
      checks++;
      if (!ok || d !== mem_word(32'h40)) begin
         errors++;
         $display("FAIL wr_data: ok=%b data=%h want %h", ok, d, mem_word(32'h40));
      end
      checks++;
      if (acc_q.size() < 4 || acc_q[2] !== 32'h8 || acc_q[3] !== 32'h40) begin
         errors++;
         $display("FAIL wr_issue: want 0,4,8,40 log size %0d", acc_q.size());
      end
      stall_left = 0;
   endtask

   task automatic test_wrap();
      wr_pct = 0; lat_min = 1; lat_max = 1;
      do_reset();
      repeat (8) @(negedge clk);
      #2;
      checks++;
      if (w_acc.size() != 4 || w_acc[0] !== 32'hFFFF_FFF8 || w_acc[1] !== 32'hFFFF_FFFC ||
          w_acc[2] !== 32'h0 || w_acc[3] !== 32'h4) begin
         errors++;
         $display("FAIL wrap_issue: %0d issues, want fffffff8,fffffffc,0,4", w_acc.size());
      end
      checks++;
      if (w_mem_read !== 1'b0) begin errors++; $display("FAIL wrap_idle: mem_read got %b want 0", w_mem_read); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      int lat;
      bit ok, wok;
      wr_pct = 0; lat_min = 5; lat_max = 5;
      do_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (acc_q.size() != 3) begin errors++; $display("FAIL rm_outstanding: got %0d want 3", acc_q.size()); end
      rst         = 1'b0;
      cpu_read    = 1'b1;
      cpu_address = 32'h0;
      #1;
      checks++;
      if (mem_read !== 1'b0 || cpu_readdatavalid !== 1'b0) begin
         errors++;
         $display("FAIL rm_reset: mem_read=%b rdv=%b want 0 0", mem_read, cpu_readdatavalid);
      end
      lat_min = 1; lat_max = 1;
      @(negedge clk);
      rst      = 1'b1;
      cpu_read = 1'b0;
      #1;
      checks++;
      if (mem_read !== 1'b1 || mem_address !== 32'h0) begin
         errors++;
         $display("FAIL rm_restart: mem_read=%b addr=%h want 1 and 0", mem_read, mem_address);
      end
      @(negedge clk);
      cpu_fetch(32'h0, 20, d, lat, ok, wok);
      checks++;
      if (!ok || d !== mem_word(32'h0)) begin
         errors++;
         $display("FAIL rm_data: ok=%b data=%h want %h", ok, d, mem_word(32'h0));
      end
   endtask

   task automatic test_random();
      logic [31:0] d, pc;
      int lat, r;
      bit ok, wok;
      wr_pct = 25; lat_min = 1; lat_max = 4;
      do_reset();
      pc = 32'h0;
      for (int i = 0; i < 250; i++) begin
         r = $urandom_range(99);
         if (r < 2) pc = 32'hFFFF_FFF0;
         else if (r < 4) pc = {22'h0, 8'($urandom), 2'b10};
         else if (r < 14) pc = {20'h0, 10'($urandom), 2'b00};
         if ($urandom_range(9) == 0) begin
            repeat ($urandom_range(3, 1)) begin
               #1;
               checks++;
               if (cpu_readdatavalid !== 1'b0 || cpu_waitrequest !== 1'b0) begin
                  errors++;
                  $display("FAIL idle_out: rdv=%b waitreq=%b want 0 0", cpu_readdatavalid, cpu_waitrequest);
               end
               @(negedge clk);
            end
         end
         cpu_fetch(pc, 300, d, lat, ok, wok);
         checks++;
         if (!ok || d !== mem_word(pc)) begin
            errors++;
            $display("FAIL rnd_data: addr=%h ok=%b data=%h want %h", pc, ok, d, mem_word(pc));
         end
         checks++;
         if (!wok) begin
            errors++;
            $display("FAIL rnd_waitreq: addr=%h waitrequest differed from !readdatavalid, want equal", pc);
         end
         pc = pc + 32'd4;
      end
   endtask

   initial begin
      rst              = 1'b0;
      cpu_read         = 1'b0;
      cpu_address      = 32'h0;
      cpu_byteenable   = 4'h0;
      w_cpu_read       = 1'b0;
      w_cpu_address    = 32'h0;
      w_cpu_byteenable = 4'h0;
      w_mem_readdata   = 32'h0;
      w_mem_waitrequest   = 1'b0;
      w_mem_readdatavalid = 1'b0;
      test_reset();
      test_full();
      test_sequential();
      test_branch();
      test_waitreq();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
